// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes, dmem waits.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
//
// state    | meaning
// RUN      | normal issue; load-use and taken-branch handling
// MEM_WAIT | data memory stalled; whole pipe held
// FLUSH    | extra IF flush cycles after a taken branch
// FAULT    | memory timeout; pipeline frozen until reset
module pipeline_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemoryRead,
  input  logic [4:0]       IDEX_rd,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             branch,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IF_flush,
  output logic             IDEX_bubble,
  output logic             pipe_hold,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, FAULT} state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [1:0] flush_cnt;
  logic       lu_haz;
  logic       mw;

  assign lu_haz = IDEX_MemoryRead && (IDEX_rd != 5'd0) &&
                  ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
  assign mw     = dmem_req && !dmem_ready;

  // Outputs respond in the same cycle as the hazard inputs.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IF_flush    = 1'b0;
    IDEX_bubble = 1'b0;
    pipe_hold   = 1'b0;
    if (!rst_n) begin
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IF_flush    = 1'b1;
      IDEX_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            pipe_hold = 1'b1;
          end else if (lu_haz) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEX_bubble = 1'b1;
          end else if (branch) begin
            IF_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mw) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            pipe_hold = 1'b1;
          end
        end
        FLUSH: begin
          if (mw) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            pipe_hold = 1'b1;
          end else begin
            IF_flush = 1'b1;
          end
        end
        FAULT: begin
          PCWrite     = 1'b0;
          IFIDWrite   = 1'b0;
          IF_flush    = 1'b1;
          IDEX_bubble = 1'b1;
          pipe_hold   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      flush_cnt <= 2'd0;
      mem_fault <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            wait_cnt <= 8'd1;
            state    <= MEM_WAIT;
          end else if (!lu_haz && branch && (BRANCH_PENALTY > 1)) begin
            flush_cnt <= 2'(BRANCH_PENALTY - 1);
            state     <= FLUSH;
          end
        end
        MEM_WAIT: begin
          if (!mw) begin
            wait_cnt <= 8'd0;
            state    <= RUN;
          end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            mem_fault <= 1'b1;
            state     <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FLUSH: begin
          // A memory stall abandons whatever flush is left.
          if (mw) begin
            flush_cnt <= 2'd0;
            wait_cnt  <= 8'd1;
            state     <= MEM_WAIT;
          end else if (flush_cnt <= 2'd1) begin
            flush_cnt <= 2'd0;
            state     <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 2'd1;
          end
        end
        FAULT: state <= FAULT;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!PCWrite && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (IF_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
